// File: rtl/norm_round_seq.sv
// norm_round_seq: converts the accumulated two's-complement sum of aligned
// partial products back to sign / exponent / mantissa form, relative to the
// shared max_exp. Sequence: absolute value, leading-one normalization,
// round-to-nearest-even, exponent range check. One operation in flight.
// Optional build macro: NORM_LZC_FAST_EN selects a single-cycle normalizer
// (leading-zero count plus barrel shift) instead of the one-bit-per-cycle
// iterative shifter used by default.
module norm_round_seq #(
   parameter int SUM_W     = 19,
   parameter int FRAC_BITS = 13,
   parameter int MAN_W     = 3
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [SUM_W-1:0] i_sum,
   input  logic [5:0]       i_max_exp,
   output logic             o_valid,
   input  logic             i_ready,
   output logic             o_sign,
   output logic [5:0]       o_exp,
   output logic [MAN_W-1:0] o_mant,
   output logic             o_of,
   output logic             o_uf
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ABS   = 3'd1;
   localparam logic [2:0] S_NORM  = 3'd2;
   localparam logic [2:0] S_ROUND = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   // Exponent of the sum's MSB position relative to max_exp.
   localparam logic signed [7:0] E_OFS = 8'(SUM_W - 1 - FRAC_BITS);
   // Packed range-check result: {sign, of, uf, exp[5:0], mant}.
   localparam int RES_W = 9 + MAN_W;

   // Round-to-nearest-even on the normalized magnitude; returns {carry, m}.
   function automatic logic [MAN_W:0] round_rne(input logic [SUM_W-1:0] mag);
      logic [MAN_W-1:0] m;
      logic             g;
      logic             s;
      logic             up;
      m  = mag[SUM_W-1 -: MAN_W];
      g  = mag[SUM_W-1-MAN_W];
      s  = |mag[SUM_W-2-MAN_W:0];
      up = g & (s | m[0]);
      return {1'b0, m} + {{MAN_W{1'b0}}, up};
   endfunction

   // Exponent range check: saturate on overflow, flush to zero on underflow.
   function automatic logic [RES_W-1:0] range_sat(input logic signed [7:0] e,
                                                  input logic [MAN_W-1:0] m,
                                                  input logic             sign);
      if (e > 8'sd63)
         return {sign, 1'b1, 1'b0, 6'd63, {MAN_W{1'b1}}};
      else if (e < 8'sd1)
         return {1'b0, 1'b0, 1'b1, 6'd0, {MAN_W{1'b0}}};
      else
         return {sign, 1'b0, 1'b0, e[5:0], m};
   endfunction

`ifdef NORM_LZC_FAST_EN
   localparam int LZ_W = $clog2(SUM_W + 1);

   // Leading-zero count; the highest set bit wins as the scan ascends.
   function automatic logic [LZ_W-1:0] lzc(input logic [SUM_W-1:0] v);
      logic [LZ_W-1:0] n;
      n = '0;
      for (int i = 0; i < SUM_W; i++)
         if (v[i]) n = LZ_W'(SUM_W - 1 - i);
      return n;
   endfunction
`endif

   logic [2:0]              state_q, state_d;
   logic [SUM_W-1:0]        sum_q, sum_d;
   logic [5:0]              mexp_q, mexp_d;
   logic                    sign_q, sign_d;
   logic [SUM_W-1:0]        mag_q, mag_d;
   logic signed [7:0]       e_q, e_d;
   logic                    osign_q, osign_d;
   logic [5:0]              oexp_q, oexp_d;
   logic [MAN_W-1:0]        omant_q, omant_d;
   logic                    of_q, of_d;
   logic                    uf_q, uf_d;

   logic [SUM_W-1:0]        abs_mag;
   logic [MAN_W:0]          rnd;
   logic [MAN_W-1:0]        m_rnd;
   logic signed [7:0]       e_rnd;
   logic [RES_W-1:0]        res;

   assign abs_mag = sum_q[SUM_W-1] ? -sum_q : sum_q;
   assign rnd     = round_rne(mag_q);
   assign m_rnd   = rnd[MAN_W] ? {1'b1, {(MAN_W-1){1'b0}}} : rnd[MAN_W-1:0];
   assign e_rnd   = rnd[MAN_W] ? e_q + 8'sd1 : e_q;
   assign res     = range_sat(e_rnd, m_rnd, sign_q);

   // Next-state and datapath update for the IDLE/ABS/NORM/ROUND/DONE sequence.
   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      mexp_d  = mexp_q;
      sign_d  = sign_q;
      mag_d   = mag_q;
      e_d     = e_q;
      osign_d = osign_q;
      oexp_d  = oexp_q;
      omant_d = omant_q;
      of_d    = of_q;
      uf_d    = uf_q;
      case (state_q)
         // capture boundary: accept a new sum
         S_IDLE: begin
            if (i_valid) begin
               sum_d   = i_sum;
               mexp_d  = i_max_exp;
               state_d = S_ABS;
            end
         end
         // abs boundary: sign split and starting exponent
         S_ABS: begin
            sign_d = sum_q[SUM_W-1];
            mag_d  = abs_mag;
            e_d    = $signed({2'b00, mexp_q}) + E_OFS;
            if (abs_mag == '0) begin
               osign_d = 1'b0;
               oexp_d  = 6'd0;
               omant_d = '0;
               of_d    = 1'b0;
               uf_d    = 1'b0;
               state_d = S_DONE;
            end else begin
               state_d = S_NORM;
            end
         end
         // normalize boundary: bring the leading one to the MSB
         S_NORM: begin
`ifdef NORM_LZC_FAST_EN
            mag_d   = mag_q << lzc(mag_q);
            e_d     = e_q - $signed({{(8-LZ_W){1'b0}}, lzc(mag_q)});
            state_d = S_ROUND;
`else
            if (mag_q[SUM_W-1]) begin
               state_d = S_ROUND;
            end else begin
               mag_d = mag_q << 1;
               e_d   = e_q - 8'sd1;
            end
`endif
         end
         // round boundary: RNE plus range check into the output registers
         S_ROUND: begin
            {osign_d, of_d, uf_d, oexp_d, omant_d} = res;
            state_d = S_DONE;
         end
         S_DONE: begin
            if (i_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control state and result registers; reset aborts any operation.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         osign_q <= 1'b0;
         oexp_q  <= 6'd0;
         omant_q <= '0;
         of_q    <= 1'b0;
         uf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         osign_q <= osign_d;
         oexp_q  <= oexp_d;
         omant_q <= omant_d;
         of_q    <= of_d;
         uf_q    <= uf_d;
      end
   end

   // Working datapath registers; always rewritten before use, so no reset.
   always_ff @(posedge i_clk) begin
      sum_q  <= sum_d;
      mexp_q <= mexp_d;
      sign_q <= sign_d;
      mag_q  <= mag_d;
      e_q    <= e_d;
   end

   assign o_ready = (state_q == S_IDLE);
   assign o_valid = (state_q == S_DONE);
   assign o_sign  = osign_q;
   assign o_exp   = oexp_q;
   assign o_mant  = omant_q;
   assign o_of    = of_q;
   assign o_uf    = uf_q;

endmodule

// File: tb/tb_norm_round_seq.sv
// tb_norm_round_seq: randomized and directed bench for norm_round_seq with a
// behavioural reference model (integer magnitude, remainder-based RNE).
module tb_norm_round_seq;

   localparam int SUM_W     = 19;
   localparam int FRAC_BITS = 13;
   localparam int MAN_W     = 3;
`ifdef NORM_LZC_FAST_EN
   localparam int FAST = 1;
`else
   localparam int FAST = 0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             i_valid = 1'b0;
   logic             o_ready;
   logic [SUM_W-1:0] i_sum = '0;
   logic [5:0]       i_max_exp = '0;
   logic             o_valid;
   logic             i_ready = 1'b1;
   logic             o_sign;
   logic [5:0]       o_exp;
   logic [MAN_W-1:0] o_mant;
   logic             o_of;
   logic             o_uf;

   int n_checks = 0;
   int n_fail   = 0;
   bit mon_en   = 1'b0;
   int exp_sign, exp_exp, exp_mant, exp_of, exp_uf, exp_lat;

   norm_round_seq #(.SUM_W(SUM_W), .FRAC_BITS(FRAC_BITS), .MAN_W(MAN_W)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_sum(i_sum), .i_max_exp(i_max_exp), .o_valid(o_valid), .i_ready(i_ready),
      .o_sign(o_sign), .o_exp(o_exp), .o_mant(o_mant), .o_of(o_of), .o_uf(o_uf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint got, input longint want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
      end
   endtask

   // Reference: value = mag * 2^(max_exp - FRAC_BITS); mantissa is the top
   // MAN_W bits below the leading one, rounded by comparing the discarded
   // remainder against half an ulp.
   task automatic model(input logic [SUM_W-1:0] s, input int me,
                        output int sg, output int ex, output int mn,
                        output int of, output int uf, output int lat);
      longint sv, mag, m, rem, half;
      int p, e, sh;
      sv  = longint'($signed(s));
      sg  = (sv < 0) ? 1 : 0;
      mag = (sv < 0) ? -sv : sv;
      if (mag == 0) begin
         sg = 0; ex = 0; mn = 0; of = 0; uf = 0; lat = 2;
         return;
      end
      p = 0;
      for (int i = 0; i < SUM_W; i++) if (mag[i]) p = i;
      e  = me + p - FRAC_BITS;
      sh = p - (MAN_W - 1);
      if (sh > 0) begin
         m    = mag >> sh;
         rem  = mag - (m << sh);
         half = longint'(1) << (sh - 1);
         if (rem > half || (rem == half && m[0])) m = m + 1;
      end else begin
         m = mag << (-sh);
      end
      if (m == (longint'(1) << MAN_W)) begin
         m = longint'(1) << (MAN_W - 1);
         e = e + 1;
      end
      of = 0; uf = 0;
      if (e > 63) begin
         ex = 63; mn = (1 << MAN_W) - 1; of = 1;
      end else if (e < 1) begin
         ex = 0; mn = 0; sg = 0; uf = 1;
      end else begin
         ex = e; mn = int'(m);
      end
      lat = (FAST != 0) ? 4 : 4 + (SUM_W - 1 - p);
   endtask

   task automatic pin(input string name, input logic [SUM_W-1:0] s, input int me,
                      input int sg, input int ex, input int mn,
                      input int of, input int uf, input int lat);
      int a, b, c, d, f, l;
      model(s, me, a, b, c, d, f, l);
      check({name, "_model"}, longint'({a[0], b[5:0], c[MAN_W-1:0], d[0], f[0]}),
            longint'({sg[0], ex[5:0], mn[MAN_W-1:0], of[0], uf[0]}));
      check({name, "_model_lat"}, longint'(l), longint'(lat));
   endtask

   // Compare DUT result against the model on every cycle it is presented.
   always @(negedge clk) begin
      if (mon_en && rst_n && o_valid) begin
         check("sign", longint'(o_sign), longint'(exp_sign));
         check("exp",  longint'(o_exp),  longint'(exp_exp));
         check("mant", longint'(o_mant), longint'(exp_mant));
         check("of",   longint'(o_of),   longint'(exp_of));
         check("uf",   longint'(o_uf),   longint'(exp_uf));
      end
   end

   task automatic wait_ready(output bit ok);
      int cnt = 0;
      while (!o_ready && cnt < 60) begin
         @(negedge clk);
         cnt++;
      end
      ok = o_ready;
      if (!ok) check("ready_timeout", 0, 1);
   endtask

   task automatic run_op(input logic [SUM_W-1:0] s, input logic [5:0] me, input int stall);
      int  cnt;
      bit  got, ok;
      logic [MAN_W+9:0] held;
      model(s, int'(me), exp_sign, exp_exp, exp_mant, exp_of, exp_uf, exp_lat);
      wait_ready(ok);
      if (!ok) return;
      i_sum = s; i_max_exp = me; i_valid = 1'b1; i_ready = (stall == 0);
      mon_en = 1'b1;
      @(posedge clk);
      cnt = 0; got = 1'b0;
      while (cnt < 60 && !got) begin
         @(negedge clk);
         i_valid = 1'b0;
         cnt++;
         got = o_valid;
      end
      check("latency", got ? longint'(cnt) : -1, longint'(exp_lat));
      if (!got) begin
         mon_en = 1'b0;
         return;
      end
      held = {o_sign, o_exp, o_mant, o_of, o_uf, o_valid};
      for (int i = 0; i < stall; i++) begin
         i_valid = 1'b1; i_sum = SUM_W'($urandom); i_max_exp = 6'($urandom);
         @(negedge clk);
         check("stall_ready", longint'(o_ready), 0);
         check("stall_hold", longint'({o_sign, o_exp, o_mant, o_of, o_uf, o_valid}), longint'(held));
      end
      i_valid = 1'b0; i_ready = 1'b1;
      @(negedge clk);
      check("release_valid", longint'(o_valid), 0);
      check("release_ready", longint'(o_ready), 1);
      mon_en = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int sel, lat9;
      logic [SUM_W-1:0] s;
      lat9 = (FAST != 0) ? 4 : 9;

      // model pins, hand-computed
      pin("t1",      19'h02000, 10, 0, 10, 4, 0, 0, lat9);
      pin("t2neg",   19'h7E000, 10, 1, 10, 4, 0, 0, lat9);
      pin("t2min",   19'h40000, 10, 1, 15, 4, 0, 0, 4);
      pin("rne_odd", 19'h02C00, 10, 0, 10, 6, 0, 0, lat9);
      pin("rne_g0",  19'h02800, 10, 0, 10, 5, 0, 0, lat9);
      pin("rne_evn", 19'h02A00, 10, 0, 10, 5, 0, 0, lat9);
      pin("rne_cry", 19'h03C00, 10, 0, 11, 4, 0, 0, lat9);
      pin("zero",    19'h00000, 10, 0, 0,  0, 0, 0, 2);
      pin("ovf",     19'h20000, 63, 0, 63, 7, 1, 0, (FAST != 0) ? 4 : 5);
      pin("unf",     19'h00001, 2,  0, 0,  0, 0, 1, (FAST != 0) ? 4 : 22);

      // reset state
      repeat (3) @(negedge clk);
      check("rst_ready", longint'(o_ready), 1);
      check("rst_valid", longint'(o_valid), 0);
      check("rst_outs", longint'({o_sign, o_exp, o_mant, o_of, o_uf}), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // directed vectors
      run_op(19'h02000, 6'd10, 0);
      run_op(19'h7E000, 6'd10, 1);
      run_op(19'h40000, 6'd10, 0);
      run_op(19'h02C00, 6'd10, 0);
      run_op(19'h02800, 6'd10, 2);
      run_op(19'h02A00, 6'd10, 0);
      run_op(19'h03C00, 6'd10, 0);
      run_op(19'h00000, 6'd10, 0);
      run_op(19'h20000, 6'd63, 0);
      run_op(19'h00001, 6'd2,  0);
      run_op(19'h02000, 6'd10, 3);

      // abort mid-normalization with a reset
      run_op(19'h7E000, 6'd40, 0);
      wait_ready(ok);
      if (ok) begin
         i_sum = 19'h02000; i_max_exp = 6'd10; i_valid = 1'b1;
         @(posedge clk);
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            i_valid = 1'b0;
         end
         rst_n = 1'b0;
         @(negedge clk);
         check("abort_ready", longint'(o_ready), 1);
         check("abort_valid", longint'(o_valid), 0);
         check("abort_outs", longint'({o_sign, o_exp, o_mant, o_of, o_uf}), 0);
         rst_n = 1'b1;
         @(negedge clk);
         run_op(19'h02C00, 6'd20, 0);
      end

      // randomized operations
      for (int n = 0; n < 150; n++) begin
         sel = int'($urandom_range(0, 3));
         case (sel)
            0: s = SUM_W'($urandom);
            1: s = SUM_W'($urandom) >> $urandom_range(0, SUM_W - 1);
            2: s = -(SUM_W'($urandom) >> $urandom_range(0, SUM_W - 1));
            default: begin
               case ($urandom_range(0, 4))
                  0: s = 19'h00000;
                  1: s = 19'h40000;
                  2: s = 19'h7FFFF;
                  3: s = 19'h00001;
                  default: s = 19'h3FFFF;
               endcase
            end
         endcase
         run_op(s, 6'($urandom), int'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
